core_dbg_apb_master: RTL

APB master that turns single debug-access requests from the JTAG debug transport into APB transfers toward the core debug APB slave. It sits between the JTAG-side command register, already synchronised into `clk`, and the debug APB bus. It issues one transfer at a time and honours slave wait states. It returns read data and an error flag through a valid/ready response channel.

---
 rtl/core_dbg_apb_pkg.sv | 27 ++
 rtl/core_dbg_apb_wdog.sv | 29 ++
 rtl/core_dbg_apb_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/core_dbg_apb_pkg.sv
// rtl/core_dbg_apb_pkg.sv - shared types and widths for the core debug APB master
package core_dbg_apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;
    localparam int WDOG_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] wstrb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/core_dbg_apb_wdog.sv
// rtl/core_dbg_apb_wdog.sv - saturating ACCESS-phase wait counter with expiry flag
module core_dbg_apb_wdog
    import core_dbg_apb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    // Expired while the LIMIT-th consecutive wait cycle is in progress.
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WDOG_W'(1);
        end
    end

    assign o_expired = (r_cnt >= LAST);

endmodule

// File: rtl/core_dbg_apb_master.sv
// rtl/core_dbg_apb_master.sv - debug request to APB transfer bridge; CORE_DBG_APB_TIMEOUT_EN adds the abort path
module core_dbg_apb_master
    import core_dbg_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [3:0]            pstrb,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic                  r_req_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_paddr;
    apb_req_t              r_req;
    apb_rsp_t              r_rsp;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_abort;
    logic                  w_expired;

`ifdef CORE_DBG_APB_TIMEOUT_EN
    core_dbg_apb_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state == SETUP),
        .i_inc     ((r_state == ACCESS) && !pready),
        .o_expired (w_expired)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_expired    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                // r_req_ready gates acceptance so nothing is taken while reset is still visible
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP:  w_state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_psel      <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
            r_penable   <= (w_state_nxt == ACCESS);
            r_rsp_valid <= (w_state_nxt == RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_paddr <= '0;
            r_req   <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_accept) begin
                r_paddr     <= req_addr;
                r_req.wr    <= req_wr;
                r_req.wdata <= req_wdata;
                r_req.wstrb <= req_wr ? req_wstrb : 4'h0;
            end
            if (w_capture) begin
                r_rsp.err   <= pslverr;
                r_rsp.rdata <= (r_req.wr || pslverr) ? '0 : prdata;
            end else if (w_abort) begin
                r_rsp.err   <= 1'b1;
                r_rsp.rdata <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_req.wr;
    assign pwdata    = r_req.wdata;
    assign pstrb     = r_req.wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;

endmodule
